sprite_pixel_fetch: RTL and testbench

SPRITE_PIXEL_FETCH -- requirements
Module: sprite_pixel_fetch

---
 rtl/sprite_pkg.sv | 15 +
 rtl/sprite_rom.sv | 16 +
 rtl/sprite_pixel_fetch.sv | 133 +++++++++++++
 tb/tb_sprite_pixel_fetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared widths, transparency default and the sprite ROM image for the sprite fetch path.
package sprite_pkg;

   localparam int COORD_W = 10;
   localparam int IDX_W   = 5;
   localparam logic [IDX_W-1:0] TRANSPARENT_DEFAULT = 5'd0;

   // Fixed sprite image, indexed by flat ROM address; reproducible without any external file.
   function automatic logic [IDX_W-1:0] sprite_texel(input logic [15:0] a);
      logic [15:0] t;
      t = a * 16'd13 + (a >> 4) * 16'd7;
      return t[IDX_W-1:0];
   endfunction

endpackage

// File: rtl/sprite_rom.sv
// Sprite texel ROM: synchronous read, one cycle latency, 5-bit palette index per texel.
module sprite_rom
   import sprite_pkg::*;
#(
   parameter int ADDR_W = 10
)(
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic [IDX_W-1:0]  data
);

   always_ff @(posedge clk) begin
      data <= sprite_texel(16'(addr));
   end

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: 2-cycle fixed-latency palette index per pixel, no stalls; position changes only at vsync.
// Optional horizontal flip via SPRITE_MIRROR_EN.
module sprite_pixel_fetch
   import sprite_pkg::*;
#(
   parameter int SPRITE_W   = 16,
   parameter int SPRITE_H   = 16,
   parameter int FRAMES     = 4,
   parameter int FRAME_HOLD = 8,
   parameter logic [IDX_W-1:0] TRANSPARENT_IDX = TRANSPARENT_DEFAULT
)(
   input  logic               Clk,
   input  logic               Reset,
   input  logic               vsync_pulse,
   input  logic               pix_valid,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   input  logic [COORD_W-1:0] pos_x,
   input  logic [COORD_W-1:0] pos_y,
   input  logic               pos_wr,
   output logic               pos_ack,
   input  logic               anim_en,
`ifdef SPRITE_MIRROR_EN
   input  logic               mirror,
`endif
   output logic [IDX_W-1:0]   index,
   output logic               index_valid,
   output logic               hit
);

   localparam int PIX    = SPRITE_W * SPRITE_H;
   localparam int ADDR_W = $clog2(FRAMES * PIX);
   localparam int FS_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
   localparam int HC_W   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

   logic [COORD_W-1:0] act_x, act_y, pend_x, pend_y;
   logic               pend_full;
   logic [FS_W-1:0]    frame_sel;
   logic [HC_W-1:0]    hold_cnt;

   logic [COORD_W:0]   dx, dy, col;
   logic               in_box;
   logic [ADDR_W-1:0]  rom_addr;
   logic [IDX_W-1:0]   rom_data;
   logic               s0_valid, s0_in_box;

   // 11-bit offsets so a box hanging past column/row 1023 never wraps back to 0
   assign dx     = {1'b0, DrawX} - {1'b0, act_x};
   assign dy     = {1'b0, DrawY} - {1'b0, act_y};
   assign in_box = (DrawX >= act_x) && (dx < (COORD_W+1)'(SPRITE_W)) &&
                   (DrawY >= act_y) && (dy < (COORD_W+1)'(SPRITE_H));

`ifdef SPRITE_MIRROR_EN
   logic mirror_q;

   always_ff @(posedge Clk) begin
      if (Reset)
         mirror_q <= 1'b0;
      else if (vsync_pulse)
         mirror_q <= mirror;
   end

   assign col = mirror_q ? ((COORD_W+1)'(SPRITE_W - 1) - dx) : dx;
`else
   assign col = dx;
`endif

   assign rom_addr = ADDR_W'(int'(frame_sel) * PIX + int'(dy) * SPRITE_W + int'(col));

   sprite_rom #(
      .ADDR_W (ADDR_W)
   ) u_rom (
      .clk  (Clk),
      .addr (rom_addr),
      .data (rom_data)
   );

   // Position mailbox and animation counters; a pos_wr coincident with vsync stays pending.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         act_x     <= '0;
         act_y     <= '0;
         pend_x    <= '0;
         pend_y    <= '0;
         pend_full <= 1'b0;
         pos_ack   <= 1'b0;
         frame_sel <= '0;
         hold_cnt  <= '0;
      end else begin
         pos_ack <= pos_wr;
         if (vsync_pulse && pend_full) begin
            act_x     <= pend_x;
            act_y     <= pend_y;
            pend_full <= 1'b0;
         end
         if (pos_wr) begin
            pend_x    <= pos_x;
            pend_y    <= pos_y;
            pend_full <= 1'b1;
         end
         if (vsync_pulse && anim_en) begin
            if (hold_cnt == HC_W'(FRAME_HOLD - 1)) begin
               hold_cnt  <= '0;
               frame_sel <= (frame_sel == FS_W'(FRAMES - 1)) ? '0 : frame_sel + 1'b1;
            end else begin
               hold_cnt <= hold_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         s0_valid    <= 1'b0;
         s0_in_box   <= 1'b0;
         index_valid <= 1'b0;
         index       <= TRANSPARENT_IDX;
         hit         <= 1'b0;
      end else begin
         s0_valid    <= pix_valid;
         s0_in_box   <= in_box;
         index_valid <= s0_valid;
         if (s0_valid && s0_in_box) begin
            index <= rom_data;
            hit   <= (rom_data != TRANSPARENT_IDX);
         end else begin
            index <= TRANSPARENT_IDX;
            hit   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Scoreboard bench for sprite_pixel_fetch: driver pushes model expectations, monitor pops on DUT output.
module tb_sprite_pixel_fetch;

   localparam int SW = 16;
   localparam int SH = 16;
   localparam int NF = 4;
   localparam int FH = 8;
   localparam logic [4:0] TIDX = 5'd0;

   logic       Clk = 1'b0;
   logic       Reset, vsync_pulse, pix_valid, pos_wr, pos_ack, anim_en, mirror;
   logic [9:0] DrawX, DrawY, pos_x, pos_y;
   logic [4:0] index;
   logic       index_valid, hit;

   always #5 Clk = ~Clk;

   sprite_pixel_fetch #(
      .SPRITE_W        (SW),
      .SPRITE_H        (SH),
      .FRAMES          (NF),
      .FRAME_HOLD      (FH),
      .TRANSPARENT_IDX (TIDX)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .vsync_pulse (vsync_pulse),
      .pix_valid   (pix_valid),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .pos_x       (pos_x),
      .pos_y       (pos_y),
      .pos_wr      (pos_wr),
      .pos_ack     (pos_ack),
      .anim_en     (anim_en),
`ifdef SPRITE_MIRROR_EN
      .mirror      (mirror),
`endif
      .index       (index),
      .index_valid (index_valid),
      .hit         (hit)
   );

   typedef struct {
      int         smp;
      logic [4:0] idx;
      logic       hit;
   } exp_t;

   exp_t pix_q[$];
   int   ack_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   // Reference state: what the sprite position/animation should be, per the behavioural rules
   int m_ax, m_ay, m_px, m_py, m_fs, m_hold;
   bit m_pf, m_mir;
   bit an_cur = 1'b0;
   bit mir_cur = 1'b0;

   function automatic int rom_ref(int a);
      return (a * 13 + (a >> 4) * 7) & 31;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ax = 0; m_ay = 0; m_px = 0; m_py = 0;
      m_pf = 0; m_fs = 0; m_hold = 0; m_mir = 0;
   endtask

   task automatic step(input bit rst, input bit vs, input bit pv, input int x, input int y,
                       input bit wr, input int px, input int py);
      exp_t e;
      int   ox, oy, col;
      @(posedge Clk);
      #3;
      Reset = rst; vsync_pulse = vs; pix_valid = pv;
      DrawX = 10'(x); DrawY = 10'(y);
      pos_wr = wr; pos_x = 10'(px); pos_y = 10'(py);
      anim_en = an_cur; mirror = mir_cur;
      if (rst) begin
         pix_q.delete();
         ack_q.delete();
         model_reset();
      end else begin
         if (pv) begin
            e.smp = cyc + 1;
            ox = (x & 1023) - m_ax;
            oy = (y & 1023) - m_ay;
            if (ox >= 0 && ox < SW && oy >= 0 && oy < SH) begin
               col = ox;
`ifdef SPRITE_MIRROR_EN
               if (m_mir) col = SW - 1 - ox;
`endif
               e.idx = 5'(rom_ref(m_fs * SW * SH + oy * SW + col));
               e.hit = (e.idx != TIDX);
            end else begin
               e.idx = TIDX;
               e.hit = 1'b0;
            end
            pix_q.push_back(e);
         end
         if (wr) ack_q.push_back(cyc + 1);
         if (vs) begin
            if (m_pf) begin
               m_ax = m_px; m_ay = m_py; m_pf = 0;
            end
            if (an_cur) begin
               m_hold++;
               if (m_hold == FH) begin
                  m_hold = 0;
                  m_fs = (m_fs + 1) % NF;
               end
            end
            m_mir = mir_cur;
         end
         if (wr) begin
            m_px = px & 1023; m_py = py & 1023; m_pf = 1;
         end
      end
   endtask

   task automatic pixel(input int x, input int y);
      step(0, 0, 1, x, y, 0, 0, 0);
   endtask

   task automatic write_pos(input int px, input int py);
      step(0, 0, 0, 0, 0, 1, px, py);
   endtask

   task automatic vsync();
      step(0, 1, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: samples 1 time unit after each rising edge
   initial begin : monitor
      int   m;
      bit   exp_ack;
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         m = cyc;
         exp_ack = (ack_q.size() > 0 && ack_q[0] == m);
         if (exp_ack) void'(ack_q.pop_front());
         chk("pos_ack", 32'(pos_ack), 32'(exp_ack));
         if (index_valid === 1'b1) begin
            if (pix_q.size() == 0) begin
               chk("unexpected_valid", 32'(index_valid), 32'd0);
            end else begin
               e = pix_q.pop_front();
               chk("latency", 32'(m - 1), 32'(e.smp));
               chk("index", 32'(index), 32'(e.idx));
               chk("hit", 32'(hit), 32'(e.hit));
            end
         end else begin
            if (pix_q.size() > 0 && pix_q[0].smp == m - 1) begin
               void'(pix_q.pop_front());
               chk("missing_valid", 32'(index_valid), 32'd1);
            end
            chk("idle_index", 32'(index), 32'(TIDX));
            chk("idle_hit", 32'(hit), 32'd0);
         end
      end
   end

   initial begin : driver
      int x, y, px, py;
      bit vs, wr, pv, rst;
      Reset = 1'b1; vsync_pulse = 0; pix_valid = 0; DrawX = 0; DrawY = 0;
      pos_wr = 0; pos_x = 0; pos_y = 0; anim_en = 0; mirror = 0;
      model_reset();
      repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);

      // Commit (100,50), frame 0: first texel of the sprite
      write_pos(100, 50);
      vsync();
      pixel(100, 50);
      pixel(101, 50);
      pixel(115, 65);
      pixel(116, 50);
      pixel(99, 50);

      // Mid-frame move request stays pending until vsync
      write_pos(200, 80);
      pixel(105, 55);
      pixel(200, 80);
      vsync();
      pixel(105, 55);
      pixel(200, 80);
      pixel(207, 90);

      // Box hanging off the right edge
      write_pos(1020, 80);
      vsync();
      pixel(1023, 80);
      pixel(2, 80);
      pixel(1019, 80);
      pixel(1020, 95);

      // Simultaneous vsync and write: older pending applies, newer waits
      write_pos(10, 10);
      step(0, 1, 0, 0, 0, 1, 300, 300);
      pixel(10, 10);
      pixel(300, 300);
      vsync();
      pixel(10, 10);
      pixel(300, 300);
`ifdef SPRITE_MIRROR_EN
      mir_cur = 1'b1;
      vsync();
      pixel(300, 300);
      pixel(315, 303);
      mir_cur = 1'b0;
      vsync();
      pixel(300, 300);
`endif

      // Animation: 32 vsyncs, then frozen vsyncs
      an_cur = 1'b1;
      for (int i = 0; i < 32; i++) begin
         vsync();
         pixel(m_ax + 3, m_ay + 5);
         pixel(m_ax + 9, m_ay + 12);
      end
      an_cur = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vsync();
         pixel(m_ax + 3, m_ay + 5);
      end

      // Reset mid-line with pixels in flight
      pixel(m_ax + 1, m_ay + 1);
      pixel(m_ax + 2, m_ay + 1);
      step(1, 0, 1, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 0, 0);
      pixel(0, 0);
      pixel(3, 4);
      pixel(16, 4);

      // Randomised traffic
      an_cur = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) an_cur = ~an_cur;
`ifdef SPRITE_MIRROR_EN
         if ($urandom_range(0, 99) == 0) mir_cur = ~mir_cur;
`endif
         vs  = ($urandom_range(0, 47) == 0);
         wr  = ($urandom_range(0, 11) == 0);
         pv  = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 999) == 0);
         x   = (m_ax + int'($urandom_range(0, SW + 5)) - 3) & 1023;
         y   = (m_ay + int'($urandom_range(0, SH + 5)) - 3) & 1023;
         if ($urandom_range(0, 3) == 0) begin
            px = int'($urandom_range(0, 1023));
            py = int'($urandom_range(0, 1023));
         end else begin
            px = int'($urandom_range(0, 300));
            py = int'($urandom_range(0, 300));
         end
         step(rst, vs, pv, x, y, wr, px, py);
      end

      repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("pix_q_drained", 32'(pix_q.size()), 32'd0);
      chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
